proc_ctrl_fsm: RTL and testbench

Multi-cycle control unit that sequences the processor datapath (rom, pc, id, rf, alu, acc) through fetch/decode/execute/writeback.
Consumes the opcode from the instruction decoder and the ALU zero flag.
Drives one-cycle strobes to the PC, instruction register, register file and accumulator.
Replaces free-running combinational control so the processor retires exactly one instruction per 3–4 cycles and can halt cleanly.

---
 rtl/proc_pkg.sv | 45 ++++
 rtl/proc_ctrl_decode.sv | 31 +++
 rtl/proc_ctrl_fsm.sv | 131 +++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit: opcodes, ALU op codes,
// FSM state encoding and the decoded-instruction record.
package proc_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_AND = 4'h3;
    localparam logic [OP_W-1:0] OP_OR  = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_MOV = 4'h6;
    localparam logic [OP_W-1:0] OP_JMP = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5,
        PAUSE   = 3'd6
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_imm;
        logic       needs_wb;
        logic       is_halt;
        logic       is_jump;
        logic       is_jz;
        logic       is_mov;
        logic       is_illegal;
    } dec_t;

endpackage

// File: rtl/proc_ctrl_decode.sv
// Purely combinational map from the registered opcode to the control
// attributes the FSM needs in EXECUTE and WB.
module proc_ctrl_decode
    import proc_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output dec_t            dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin dec.alu_op = ALU_ADD; dec.needs_wb = 1'b1; end
            OP_SUB: begin dec.alu_op = ALU_SUB; dec.needs_wb = 1'b1; end
            OP_AND: begin dec.alu_op = ALU_AND; dec.needs_wb = 1'b1; end
            OP_OR:  begin dec.alu_op = ALU_OR;  dec.needs_wb = 1'b1; end
            OP_LDI: begin
                dec.alu_op      = ALU_PASS;
                dec.alu_src_imm = 1'b1;
                dec.needs_wb    = 1'b1;
            end
            OP_MOV: dec.is_mov  = 1'b1;
            OP_JMP: dec.is_jump = 1'b1;
            OP_JZ:  dec.is_jz   = 1'b1;
            OP_HLT: dec.is_halt = 1'b1;
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with sticky illegal flag
// and saturating retire counter. Define PROC_CTRL_STEP_EN for single-step PAUSE.
module proc_ctrl_fsm
    import proc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef PROC_CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             rf_we,
    output logic             acc_we,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output state_t           state_dbg
);

`ifdef PROC_CTRL_STEP_EN
    localparam state_t RETIRE_NEXT = PAUSE;
`else
    localparam state_t RETIRE_NEXT = FETCH;
`endif

    state_t           state, next_state;
    logic [OP_W-1:0]  op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    dec_t             dec;

    proc_ctrl_decode u_decode (
        .opcode (op_q),
        .dec    (dec)
    );

    // The last cycle of an instruction is EXECUTE unless it owns a WB cycle.
    assign retire = (state == WB) || (state == EXECUTE && !dec.needs_wb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE)
                op_q <= opcode;
            if (state == EXECUTE && dec.is_illegal)
                illegal_q <= 1'b1;
            if (retire && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        next_state  = state;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_op      = ALU_PASS;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        acc_we      = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: if (start) next_state = FETCH;
            FETCH: begin
                busy       = 1'b1;
                ir_load    = 1'b1;
                pc_inc     = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                busy       = 1'b1;
                next_state = EXECUTE;
            end
            EXECUTE: begin
                busy        = 1'b1;
                alu_op      = dec.alu_op;
                alu_src_imm = dec.alu_src_imm;
                rf_we       = dec.is_mov;
                pc_load     = dec.is_jump | (dec.is_jz & zero);
                if (dec.needs_wb)
                    next_state = WB;
                else if (dec.is_halt)
                    next_state = HALT;
                else
                    next_state = RETIRE_NEXT;
            end
            WB: begin
                busy        = 1'b1;
                acc_we      = 1'b1;
                alu_op      = dec.alu_op;
                alu_src_imm = dec.alu_src_imm;
                next_state  = RETIRE_NEXT;
            end
            HALT: begin
                halted = 1'b1;
                if (start) next_state = FETCH;
            end
            PAUSE: begin
                busy = 1'b1;
`ifdef PROC_CTRL_STEP_EN
                if (step) next_state = FETCH;
`else
                next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    assign illegal     = illegal_q;
    assign instr_count = cnt_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed table-driven bench for proc_ctrl_fsm, plus hand sequences for
// counter saturation (CNT_W=2 instance) and the optional PAUSE/step mode.
module tb_proc_ctrl_fsm;
    import proc_pkg::*;

    localparam logic [4:0] ST_NONE  = 5'b00000;
    localparam logic [4:0] ST_FETCH = 5'b11000;  // {ir_load,pc_inc,pc_load,rf_we,acc_we}
    localparam logic [4:0] ST_PCL   = 5'b00100;
    localparam logic [4:0] ST_RF    = 5'b00010;
    localparam logic [4:0] ST_ACC   = 5'b00001;

    logic            clk = 1'b0;
    logic            rst, start, zero, step;
    logic [OP_W-1:0] opcode;

    logic        ir_load, pc_inc, pc_load, alu_src_imm, rf_we, acc_we, busy, halted, illegal;
    logic [2:0]  alu_op;
    logic [15:0] instr_count;
    state_t      state_dbg;

    logic        s_ir_load, s_pc_inc, s_pc_load, s_alu_src_imm, s_rf_we, s_acc_we;
    logic        s_busy, s_halted, s_illegal;
    logic [2:0]  s_alu_op;
    logic [1:0]  s_instr_count;
    state_t      s_state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    proc_ctrl_fsm #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef PROC_CTRL_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .zero(zero),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .rf_we(rf_we), .acc_we(acc_we),
        .busy(busy), .halted(halted), .illegal(illegal),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    proc_ctrl_fsm #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start),
`ifdef PROC_CTRL_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .zero(zero),
        .ir_load(s_ir_load), .pc_inc(s_pc_inc), .pc_load(s_pc_load),
        .alu_op(s_alu_op), .alu_src_imm(s_alu_src_imm), .rf_we(s_rf_we), .acc_we(s_acc_we),
        .busy(s_busy), .halted(s_halted), .illegal(s_illegal),
        .instr_count(s_instr_count), .state_dbg(s_state_dbg)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic            rst;
        logic            start;
        logic [OP_W-1:0] op;
        logic            zero;
        state_t          st;
        logic [4:0]      strb;
        logic [2:0]      alu;
        logic            imm;
        logic            busy;
        logic            halted;
        logic            ill;
        int              cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic [OP_W-1:0] op,
                                input logic z, input state_t st, input logic [4:0] strb,
                                input logic [2:0] alu, input logic imm, input logic b,
                                input logic h, input logic ill, input int cnt);
        vec_t v;
        v.rst = r; v.start = s; v.op = op; v.zero = z; v.st = st; v.strb = strb;
        v.alu = alu; v.imm = imm; v.busy = b; v.halted = h; v.ill = ill; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    function automatic void add_fd(input logic [OP_W-1:0] op, input logic ill, input int cnt);
        add(0, 0, op, 0, FETCH,  ST_FETCH, ALU_PASS, 0, 1, 0, ill, cnt);
        add(0, 0, op, 0, DECODE, ST_NONE,  ALU_PASS, 0, 1, 0, ill, cnt);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_row(input int i);
        vec_t v;
        int   sat;
        v = vecs[i];
        @(negedge clk);
        rst = v.rst; start = v.start; opcode = v.op; zero = v.zero;
        #1;
        sat = (v.cnt > 3) ? 3 : v.cnt;
        check($sformatf("row%0d state", i), 32'(state_dbg), 32'(v.st));
        check($sformatf("row%0d strobes", i),
              32'({ir_load, pc_inc, pc_load, rf_we, acc_we}), 32'(v.strb));
        check($sformatf("row%0d alu", i), 32'({alu_op, alu_src_imm}), 32'({v.alu, v.imm}));
        check($sformatf("row%0d flags", i), 32'({busy, halted, illegal}),
              32'({v.busy, v.halted, v.ill}));
        check($sformatf("row%0d count", i), 32'(instr_count), 32'(v.cnt));
        check($sformatf("row%0d sat_count", i), 32'(s_instr_count), 32'(sat));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; zero = 1'b0; step = 1'b0; opcode = OP_NOP;
        repeat (2) @(negedge clk);

`ifndef PROC_CTRL_STEP_EN
        add(0, 0, OP_ADD, 0, IDLE, ST_NONE, ALU_PASS, 0, 0, 0, 0, 0);
        add(0, 1, OP_ADD, 0, IDLE, ST_NONE, ALU_PASS, 0, 0, 0, 0, 0);
        // start held high while busy must not disturb the sequence
        add(0, 1, OP_ADD, 0, FETCH,  ST_FETCH, ALU_PASS, 0, 1, 0, 0, 0);
        add(0, 1, OP_ADD, 0, DECODE, ST_NONE,  ALU_PASS, 0, 1, 0, 0, 0);
        add(0, 0, OP_HLT, 0, EXECUTE, ST_NONE, ALU_ADD, 0, 1, 0, 0, 0);
        add(0, 1, OP_HLT, 0, WB,      ST_ACC,  ALU_ADD, 0, 1, 0, 0, 0);
        add_fd(OP_LDI, 0, 1);
        add(0, 0, OP_NOP, 0, EXECUTE, ST_NONE, ALU_PASS, 1, 1, 0, 0, 1);
        add(0, 0, OP_NOP, 0, WB,      ST_ACC,  ALU_PASS, 1, 1, 0, 0, 1);
        add_fd(OP_SUB, 0, 2);
        add(0, 0, OP_SUB, 0, EXECUTE, ST_NONE, ALU_SUB, 0, 1, 0, 0, 2);
        add(0, 0, OP_SUB, 0, WB,      ST_ACC,  ALU_SUB, 0, 1, 0, 0, 2);
        add_fd(OP_AND, 0, 3);
        add(0, 0, OP_AND, 0, EXECUTE, ST_NONE, ALU_AND, 0, 1, 0, 0, 3);
        add(0, 0, OP_AND, 0, WB,      ST_ACC,  ALU_AND, 0, 1, 0, 0, 3);
        add_fd(OP_OR, 0, 4);
        add(0, 0, OP_OR, 0, EXECUTE, ST_NONE, ALU_OR, 0, 1, 0, 0, 4);
        add(0, 0, OP_OR, 0, WB,      ST_ACC,  ALU_OR, 0, 1, 0, 0, 4);
        add_fd(OP_MOV, 0, 5);
        add(0, 0, OP_MOV, 0, EXECUTE, ST_RF,   ALU_PASS, 0, 1, 0, 0, 5);
        add_fd(OP_JZ, 0, 6);
        add(0, 0, OP_JZ, 1, EXECUTE, ST_PCL,   ALU_PASS, 0, 1, 0, 0, 6);
        add_fd(OP_JZ, 0, 7);
        add(0, 0, OP_JZ, 0, EXECUTE, ST_NONE,  ALU_PASS, 0, 1, 0, 0, 7);
        add_fd(OP_JMP, 0, 8);
        add(0, 0, OP_JMP, 0, EXECUTE, ST_PCL,  ALU_PASS, 0, 1, 0, 0, 8);
        add_fd(OP_NOP, 0, 9);
        add(0, 0, OP_NOP, 1, EXECUTE, ST_NONE, ALU_PASS, 0, 1, 0, 0, 9);
        add_fd(4'hA, 0, 10);
        add(0, 0, 4'hA, 1, EXECUTE, ST_NONE,   ALU_PASS, 0, 1, 0, 0, 10);
        add_fd(OP_HLT, 1, 11);
        add(0, 0, OP_HLT, 0, EXECUTE, ST_NONE, ALU_PASS, 0, 1, 0, 1, 11);
        add(0, 0, OP_HLT, 0, HALT, ST_NONE, ALU_PASS, 0, 0, 1, 1, 12);
        add(0, 0, OP_ADD, 0, HALT, ST_NONE, ALU_PASS, 0, 0, 1, 1, 12);
        add(0, 1, OP_ADD, 0, HALT, ST_NONE, ALU_PASS, 0, 0, 1, 1, 12);
        add_fd(OP_ADD, 1, 12);
        add(0, 0, OP_ADD, 0, EXECUTE, ST_NONE, ALU_ADD, 0, 1, 0, 1, 12);
        // reset during WB: acc_we must not repeat and everything clears
        add(1, 0, OP_ADD, 0, WB,      ST_ACC,  ALU_ADD, 0, 1, 0, 1, 12);
        add(0, 0, OP_ADD, 0, IDLE,    ST_NONE, ALU_PASS, 0, 0, 0, 0, 0);
        add(0, 0, OP_ADD, 0, IDLE,    ST_NONE, ALU_PASS, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            apply_row(i);

        // saturation on the CNT_W=2 instance: five NOPs from reset
        begin
            logic [1:0] exp_sat[5];
            exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0; start = 1'b1; opcode = OP_NOP; zero = 1'b0;
            @(negedge clk); start = 1'b0;
            for (int k = 0; k < 5; k++) begin
                repeat (3) @(negedge clk);
                #1;
                check($sformatf("nop%0d sat_count", k), 32'(s_instr_count), 32'(exp_sat[k]));
                check($sformatf("nop%0d count", k), 32'(instr_count), 32'(k + 1));
            end
        end
`else
        // step mode: NOP retires into PAUSE and waits for step
        @(negedge clk); rst = 1'b0; start = 1'b1; opcode = OP_NOP; zero = 1'b0;
        #1;
        check("step reset state", 32'(state_dbg), 32'(IDLE));
        check("step reset count", 32'(instr_count), 32'd0);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("pause%0d state", k), 32'(state_dbg), 32'(PAUSE));
            check($sformatf("pause%0d busy_strobes", k),
                  32'({busy, ir_load, pc_inc, pc_load, rf_we, acc_we}), 32'b100000);
            check($sformatf("pause%0d count", k), 32'(instr_count), 32'd1);
            if (k < 9) @(negedge clk);
        end
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        #1;
        check("step fetch", 32'(state_dbg), 32'(FETCH));
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("pause2_%0d state", k), 32'(state_dbg), 32'(PAUSE));
            check($sformatf("pause2_%0d count", k), 32'(instr_count), 32'd2);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check("pause rst state", 32'(state_dbg), 32'(IDLE));
        check("pause rst busy", 32'(busy), 32'd0);
        check("pause rst count", 32'(instr_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
